hilo_div_unit: RTL

HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

---
 rtl/hilo_div_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with ALU write-back and a 32-cycle restoring divider.
// Results land in LO (quotient) and HI (remainder); divide-by-zero completes in one cycle.
module hilo_div_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        WriteHI,
    input  logic        WriteLO,
    input  logic [31:0] ALUResultHI,
    input  logic [31:0] ALUResult,
    input  logic        DivStart,
    input  logic        DivSigned,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        DivDone,
    output logic        DivByZero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    // Divider datapath: quo_q starts as the dividend magnitude and shifts quotient bits in.
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;

    assign a_mag     = (DivSigned && A[31]) ? -A : A;
    assign b_mag     = (DivSigned && B[31]) ? -B : B;
    assign rem_shift = {rem_q, quo_q[31]};

    // NOTE: every signal gets its hold/idle value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE: begin
                if (WriteHI) hi_d = ALUResultHI;
                if (WriteLO) lo_d = ALUResult;
                if (DivStart) begin
                    if (B == 32'd0) begin
                        hi_d   = A;
                        lo_d   = 32'hFFFF_FFFF;
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        quo_d     = a_mag;
                        rem_d     = 32'd0;
                        dvs_d     = b_mag;
                        neg_quo_d = DivSigned & (A[31] ^ B[31]);
                        neg_rem_d = DivSigned & A[31];
                        cnt_d     = 6'd0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_shift >= {1'b0, dvs_q}) begin
                    rem_d = rem_shift[31:0] - dvs_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                cnt_d   = 6'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // NOTE: the datapath needs no reset; it is always loaded in IDLE before RUN reads it.
    always_ff @(posedge Clk) begin
        quo_q     <= quo_d;
        rem_q     <= rem_d;
        dvs_q     <= dvs_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign Busy      = (state_q != IDLE);
    assign DivDone   = done_q;
    assign DivByZero = dbz_q;

endmodule
